// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling N_REQ bursty write requesters into one FIFO write port.
// One owner at a time; a grant ends on LAST or after MAX_BURST beats, with one idle cycle between grants.
module fifo_wr_arbiter #(
  parameter int length    = 16,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_REQ-1:0]          VALID,
  input  logic [N_REQ*length-1:0]   DATA,
  input  logic [N_REQ-1:0]          LAST,
  output logic [N_REQ-1:0]          READY,
  input  logic                      FIFO_FULL,
  output logic                      FIFO_WR,
  output logic [length-1:0]         FIFO_DATA,
  output logic [N_REQ-1:0]          GRANT,
  output logic [7:0]                BEAT_CNT
);

  localparam int IW = $clog2(N_REQ);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  // Handshake: a beat moves on a rising edge where the owner has VALID high and READY is high;
  // READY is only ever high for the owner and only while the FIFO is not full.

  logic [0:0]       r_state;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_last_owner;
  logic [N_REQ-1:0] r_grant;
  logic [7:0]       r_beat_cnt;

  logic             w_found;
  logic [IW-1:0]    w_pick;
  int               w_idx;
  logic             w_xfer;
  logic             w_beat;
  logic             w_at_max;
  logic             w_release;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(r_last_owner) + 1 + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && VALID[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IW-1:0];
      end
    end
  end

  // Outputs are gated by RESET so an abandoned burst cannot write during the reset cycle.
  assign w_xfer    = (r_state == ST_XFER) && !RESET;
  assign w_beat    = w_xfer && VALID[r_owner] && !FIFO_FULL;
  assign w_at_max  = (({1'b0, r_beat_cnt} + 9'd1) == 9'(MAX_BURST));
  assign w_release = w_beat && (LAST[r_owner] || w_at_max);

  assign READY     = r_grant & {N_REQ{w_xfer && !FIFO_FULL}};
  assign FIFO_WR   = w_beat;
  assign FIFO_DATA = DATA[r_owner*length +: length];
  assign GRANT     = r_grant;
  assign BEAT_CNT  = r_beat_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_ARB;
      r_owner      <= '0;
      r_grant      <= '0;
      r_beat_cnt   <= '0;
      r_last_owner <= IW'(N_REQ - 1);
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_found) begin
            r_state    <= ST_XFER;
            r_owner    <= w_pick;
            r_grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
            r_beat_cnt <= '0;
          end
        end
        default: begin
          if (w_release) begin
            r_state      <= ST_ARB;
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_last_owner <= r_owner;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat sources, an expected-write queue,
// a grant-order vector table and hand-written burst/full/reset sequences.
module tb_fifo_wr_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int MB = 8;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [N-1:0]   VALID;
  logic [N*W-1:0] DATA;
  logic [N-1:0]   LAST;
  logic [N-1:0]   READY;
  logic           FIFO_FULL;
  logic           FIFO_WR;
  logic [W-1:0]   FIFO_DATA;
  logic [N-1:0]   GRANT;
  logic [7:0]     BEAT_CNT;

  fifo_wr_arbiter #(.length(W), .N_REQ(N), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RESET(RESET), .VALID(VALID), .DATA(DATA), .LAST(LAST),
    .READY(READY), .FIFO_FULL(FIFO_FULL), .FIFO_WR(FIFO_WR),
    .FIFO_DATA(FIFO_DATA), .GRANT(GRANT), .BEAT_CNT(BEAT_CNT)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  logic [W:0] src_mem [N][32];
  int         src_rd [N];
  int         src_wr [N];

  logic         s_wr;
  logic [N-1:0] s_grant;
  logic [N-1:0] s_ready;
  logic [7:0]   s_cnt;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_grant;
  } vec_t;
  vec_t vecs[10];

  logic [N-1:0] a_g[7];
  logic         a_w[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
  endtask

  task automatic load(input int r, input logic [W-1:0] w, input logic l);
    src_mem[r][src_wr[r]] = {l, w};
    src_wr[r]++;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return W'($urandom_range(0, 65535));
  endfunction

  // One clock: drive source fronts, sample/check at negedge, retire accepted beats.
  task automatic step();
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) begin
      VALID[i]       = (src_rd[i] < src_wr[i]);
      DATA[i*W +: W] = src_mem[i][src_rd[i] % 32][W-1:0];
      LAST[i]        = src_mem[i][src_rd[i] % 32][W];
    end
    @(negedge CLK);
    s_wr    = FIFO_WR;
    s_grant = GRANT;
    s_ready = READY;
    s_cnt   = BEAT_CNT;
    chk("wr_while_full", 32'(FIFO_WR && FIFO_FULL), 0);
    chk("grant_onehot0", 32'($onehot0(GRANT)), 1);
    chk("ready_owner_only", 32'(READY & ~GRANT), 0);
    if (FIFO_WR) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h required=no_write", FIFO_DATA);
      end else begin
        e = exp_q.pop_front();
        chk("fifo_data", 32'(FIFO_DATA), 32'(e));
      end
    end
    for (int i = 0; i < N; i++)
      if (VALID[i] && READY[i]) src_rd[i]++;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    FIFO_FULL = 1'b0;
    clear_src();
    exp_q.delete();
    step();
    step();
    RESET = 1'b0;
    step();
    chk("rst_grant", 32'(s_grant), 0);
    chk("rst_cnt", 32'(s_cnt), 0);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_wr", 32'(s_wr), 0);
  endtask

  // ---------------- test sequences ----------------
  initial begin
    logic [W-1:0] w;
    int           nw;
    int           gi;

    RESET     = 1'b1;
    FIFO_FULL = 1'b0;
    VALID     = '0;
    LAST      = '0;
    DATA      = '0;
    clear_src();
    @(posedge CLK);
    #1;

    // Requester 1 three-beat packet, then requester 3 two-beat packet.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      w = rnd_word(); load(1, w, k == 2); exp_q.push_back(w);
    end
    for (int k = 0; k < 2; k++) begin
      w = rnd_word(); load(3, w, k == 1); exp_q.push_back(w);
    end
    a_g = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000};
    a_w = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      step();
      chk("a_grant", 32'(s_grant), 32'(a_g[k]));
      chk("a_wr", 32'(s_wr), 32'(a_w[k]));
    end
    step();
    chk("a_idle", 32'(s_grant), 0);
    chk("a_drained", 32'(exp_q.size()), 0);

    // Grant-order table: each row offers one single-beat packet per masked requester.
    vecs[0] = '{4'b1010, 4'b0010};
    vecs[1] = '{4'b1010, 4'b1000};
    vecs[2] = '{4'b1111, 4'b0001};
    vecs[3] = '{4'b1111, 4'b0010};
    vecs[4] = '{4'b0001, 4'b0001};
    vecs[5] = '{4'b0100, 4'b0100};
    vecs[6] = '{4'b1011, 4'b1000};
    vecs[7] = '{4'b0110, 4'b0010};
    vecs[8] = '{4'b1100, 4'b0100};
    vecs[9] = '{4'b0011, 4'b0001};
    do_reset();
    for (int r = 0; r < 10; r++) begin
      clear_src();
      gi = 0;
      for (int i = 0; i < N; i++) begin
        w = rnd_word();
        if (vecs[r].valid[i]) load(i, w, 1'b1);
        if (vecs[r].exp_grant[i]) begin
          gi = i;
          exp_q.push_back(w);
        end
      end
      step();
      chk("tbl_idle", 32'(s_grant), 0);
      step();
      chk("tbl_grant", 32'(s_grant), 32'(vecs[r].exp_grant));
      chk("tbl_wr", 32'(s_wr), 1);
      chk("tbl_ready", 32'(s_ready), 32'(1 << gi));
    end
    clear_src();
    step();
    chk("tbl_drained", 32'(exp_q.size()), 0);

    // Requester 2 streams 20 beats without LAST: forced release after beats 8 and 16.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      w = rnd_word(); load(2, w, 1'b0); exp_q.push_back(w);
    end
    nw = 0;
    for (int c = 0; c < 80 && nw < 20; c++) begin
      step();
      if (s_wr) begin
        chk("b_cnt", 32'(s_cnt), 32'(nw % MB));
        nw++;
        if (nw == 8 || nw == 16) begin
          step();
          chk("b_bubble", 32'(s_grant), 0);
          chk("b_bubble_wr", 32'(s_wr), 0);
          step();
          chk("b_regrant", 32'(s_grant), 32'(4'b0100));
          if (s_wr) begin
            chk("b_cnt", 32'(s_cnt), 32'(nw % MB));
            nw++;
          end
        end
      end
    end
    chk("b_writes", 32'(nw), 20);
    step();
    chk("b_hold_grant", 32'(s_grant), 32'(4'b0100));
    chk("b_hold_cnt", 32'(s_cnt), 4);
    chk("b_drained", 32'(exp_q.size()), 0);

    // FIFO_FULL for 5 cycles while the LAST beat is presented.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      w = rnd_word(); load(0, w, k == 2); exp_q.push_back(w);
    end
    step();
    step();
    chk("c_grant", 32'(s_grant), 32'(4'b0001));
    chk("c_ready", 32'(s_ready), 32'(4'b0001));
    step();
    chk("c_cnt1", 32'(s_cnt), 1);
    FIFO_FULL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("c_full_wr", 32'(s_wr), 0);
      chk("c_full_ready", 32'(s_ready), 0);
      chk("c_full_cnt", 32'(s_cnt), 2);
      chk("c_full_grant", 32'(s_grant), 32'(4'b0001));
    end
    FIFO_FULL = 1'b0;
    step();
    chk("c_last_wr", 32'(s_wr), 1);
    chk("c_last_cnt", 32'(s_cnt), 2);
    step();
    chk("c_release", 32'(s_grant), 0);
    chk("c_drained", 32'(exp_q.size()), 0);

    // Reset in the middle of a burst on requester 1.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      w = rnd_word(); load(1, w, k == 4); exp_q.push_back(w);
    end
    step();
    step();
    chk("d_grant", 32'(s_grant), 32'(4'b0010));
    step();
    chk("d_cnt", 32'(s_cnt), 1);
    RESET = 1'b1;
    exp_q.delete();
    step();
    chk("d_rst_wr", 32'(s_wr), 0);
    RESET = 1'b0;
    clear_src();
    w = rnd_word(); load(0, w, 1'b1); exp_q.push_back(w);
    w = rnd_word(); load(1, w, 1'b1); exp_q.push_back(w);
    step();
    chk("d_after_grant", 32'(s_grant), 0);
    chk("d_after_wr", 32'(s_wr), 0);
    chk("d_after_cnt", 32'(s_cnt), 0);
    step();
    chk("d_regrant", 32'(s_grant), 32'(4'b0001));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    chk("d_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter length, default 16, FIFO data word width in bits.
REQ-002 SHALL have parameter N_REQ, default 4, number of write requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 8, max beats per grant (1..255).
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port VALID  input  N_REQ  per-requester data valid.
REQ-007 SHALL have port DATA  input  N_REQ*length  per-requester word; requester i at bits [i*length +: length].
REQ-008 SHALL have port LAST  input  N_REQ  per-requester end-of-packet flag, qualified by VALID.
REQ-009 SHALL have port READY  output  N_REQ  per-requester beat accept.
REQ-010 SHALL have port FIFO_FULL  input  1  FULL from the FIFO write side.
REQ-011 SHALL have port FIFO_WR  output  1  FIFO write strobe.
REQ-012 SHALL have port FIFO_DATA  output  length  FIFO write data.
REQ-013 SHALL have port GRANT  output  N_REQ  one-hot current owner; all-zero when idle.
REQ-014 SHALL have port BEAT_CNT  output  8  beats accepted in current grant.

Function
REQ-015 SHALL implement a two-state FSM: ARB (no owner) and XFER (one owner).
REQ-016 In ARB with any VALID high, SHALL register GRANT for the first VALID requester searching round-robin from index (last_owner+1) mod N_REQ, and move to XFER; VALID-to-GRANT latency is 1 cycle.
REQ-017 In ARB, SHALL hold READY, FIFO_WR at 0 and GRANT at 0.
REQ-018 In XFER, beat accepted = VALID[g] && !FIFO_FULL, where g is the owner index.
REQ-019 In XFER, READY[g] SHALL equal !FIFO_FULL combinationally; READY of non-owners SHALL be 0.
REQ-020 FIFO_WR SHALL equal the beat accepted signal, and FIFO_DATA SHALL equal DATA of the owner, both combinationally, with no added latency.
REQ-021 SHALL never assert FIFO_WR while FIFO_FULL is 1.
REQ-022 On each accepted beat, BEAT_CNT SHALL increment by 1; it SHALL clear to 0 on entry to ARB.
REQ-023 SHALL return to ARB after an accepted beat with LAST[g]=1, or after the accepted beat that brings BEAT_CNT to MAX_BURST, whichever occurs first.
REQ-024 On release, last_owner SHALL be set to g.
REQ-025 There SHALL be exactly one ARB bubble cycle between consecutive grants.
REQ-026 If VALID[g] is low or FIFO_FULL is high, XFER SHALL hold with no beat and no count change.
REQ-027 If LAST coincides with FIFO_FULL=1, the beat SHALL NOT be accepted and the grant SHALL NOT be released.
REQ-028 A requester forced off at MAX_BURST SHALL keep its remaining beats; it competes normally in the next ARB cycle.
REQ-029 VALID changes on non-owners during XFER SHALL have no effect.
REQ-030 GRANT SHALL never have more than one bit set.

Reset
REQ-031 With RESET high at a rising edge, SHALL set state to ARB, GRANT to 0, BEAT_CNT to 0, last_owner to N_REQ-1 (requester 0 first priority), and hold READY and FIFO_WR at 0.
REQ-032 Reset mid-burst SHALL abandon the burst without any further FIFO_WR; the next grant follows REQ-031 priority.

Verification
REQ-033 After reset, VALID=4'b1010 -> GRANT=4'b0010 one cycle later; 3 beats with LAST on the 3rd -> 3 FIFO_WR pulses with matching data, then GRANT=0 for 1 cycle, then GRANT=4'b1000.
REQ-034 All 4 requesters VALID continuously, with single-beat LAST packets -> grant order 0,1,2,3,0 with a bubble between each.
REQ-035 MAX_BURST=8, requester 2 streams 20 beats with no LAST -> released after beats 8 and 16; with only requester 2 valid it is re-granted; 20 total writes in order.
REQ-036 FIFO_FULL high for 5 cycles mid-burst, including a cycle where LAST is presented -> no FIFO_WR and READY=0 during FULL, BEAT_CNT frozen, LAST beat written after FULL drops.
REQ-037 RESET asserted at beat 3 of a burst on requester 1 -> next cycle GRANT=0 and FIFO_WR=0; with VALID=4'b0011 afterward, GRANT=4'b0001.
REQ-038 The bench SHALL check FIFO_WR=0 whenever FIFO_FULL=1, and GRANT one-hot or zero, every cycle.
